adc_snap_ctrl: RTL
==================

# adc_snap_ctrl

Capture sequencer for an ADC snapshot buffer. Software arms a capture through a control word; the block waits for an immediate or external trigger and writes a fixed-length run of valid ADC samples into a snapshot BRAM. It then reports completion and the word count through a status word, which is read back over OPB through a simulink2ppc register. The block sits in the user clock domain, between the ADC sample stream, the snapshot BRAM write port, and the software control/status registers.

## Interface
Parameters:
- ADDR_W, 10, BRAM address width; capture length is 2^ADDR_W words
- DATA_W, 32, sample word width

Ports:
- user_clk  in  1  sole clock; all logic is on the rising edge
- user_rst  in  1  asynchronous, active-high reset
- ctrl  in  32  software control word: bit0 arm (rising-edge sensitive), bit1 trig_sel (0 = immediate, 1 = external), bit2 abort (level); other bits ignored
- din  in  DATA_W  ADC sample word
- din_valid  in  1  din qualifier
- trig_in  in  1  external trigger, level-sampled
- bram_addr  out  ADDR_W  BRAM write address
- bram_data  out  DATA_W  BRAM write data
- bram_we  out  1  BRAM write enable
- status  out  32  bit31 done, bit30 busy (ARMED or CAPTURE), bit29 trig_seen, bits[ADDR_W:0] words written; other bits 0
- done  out  1  high while in DONE

## Operation
- FSM states: IDLE, ARMED, CAPTURE, DONE.
- arm_edge = ctrl[0] AND NOT ctrl0_q, where ctrl0_q is ctrl[0] registered.
- IDLE -> ARMED on arm_edge. The word counter clears and trig_seen clears on that same edge.
- ARMED -> CAPTURE:
  - trig_sel=0: on the cycle after entry, unconditionally.
  - trig_sel=1: on the first cycle trig_in=1. trig_seen is set at that cycle.
- CAPTURE: on each cycle with din_valid=1:
  - register bram_data<=din, bram_addr<=count[ADDR_W-1:0], bram_we<=1
  - count<=count+1
  - on cycles with din_valid=0, bram_we<=0.
- CAPTURE -> DONE on the write of word 2^ADDR_W-1. count then holds 2^ADDR_W and never wraps.
- DONE -> ARMED on arm_edge (re-arm). Counter and trig_seen clear on that edge.
- abort (ctrl[2]=1) in any state forces IDLE on the next edge:
  - count is held
  - bram_we<=0
  - abort has priority over arm_edge and over capture completion.
- arm_edge while in ARMED or CAPTURE is ignored.
- trig_sel is sampled every cycle in ARMED. A change takes effect immediately.
- status and done are registered from state, count and trig_seen.

## Timing
- Reset values:
  - state IDLE
  - count 0
  - ctrl0_q 0
  - trig_seen 0
  - bram_addr 0, bram_data 0, bram_we 0
  - status 0, done 0
- Latencies, with ctrl[0] rising at cycle n:
  - arm_edge is true at n.
  - State is ARMED at n+1, and status busy=1 at n+2.
- Immediate trigger: CAPTURE from n+2. A din_valid at n+2 produces bram_we=1 at n+3.
- External trigger: trig_in=1 at cycle t in ARMED gives CAPTURE at t+1. The trig_in cycle's sample is not written.
- Write latency is 1 cycle from the din_valid cycle to the bram_we/addr/data cycle.
- Completion: the final write cycle and DONE entry coincide. done=1 and status bit31=1 one cycle later.
- Throughput: one word per cycle with din_valid held high. A full capture takes exactly 2^ADDR_W valid cycles.
- ctrl[0] held high generates only one arm. Re-arming requires the bit to return to 0 for at least one cycle.
- Reset asserted mid-capture clears everything immediately, with no further BRAM writes.

## Test plan
- Reset: assert user_rst mid-CAPTURE (count=37) -> bram_we=0 and status=0 immediately; FSM IDLE after release.
- Immediate capture (ADDR_W=4, din=ramp 0..15 with din_valid=1) -> 16 writes, addr 0..15 with data 0..15, then done=1 and status=0x8000_0010.
- External trigger (trig_sel=1, trig_in pulse after 20 cycles, din_valid 50% duty) -> first written word is the first valid sample after the trigger cycle; status bit29=1; exactly 16 writes.
- Gaps: din_valid low for 5 cycles mid-capture -> bram_we=0 for 5 cycles; addr continues from 7 to 8 with no skip.
- Abort at count=9, then arm -> IDLE with status bits[4:0]=9 and busy=0; after arm, count restarts at 0.
- Arm held high, plus re-arm from DONE -> no second capture until ctrl[0] toggles 0->1; the toggle restarts at addr 0.

Source files
------------

// File: rtl/adc_snap_ctrl.sv
// Snapshot capture sequencer: software arms a capture, a trigger starts it, and
// 2^ADDR_W valid ADC samples are written to BRAM before completion is reported.
module adc_snap_ctrl #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       ctrl,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              trig_in,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_data,
   output logic              bram_we,
   output logic [31:0]       status,
   output logic              done
);

   localparam int unsigned      CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              trig_seen_q, trig_seen_d;
   logic              ctrl0_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;
   logic [31:0]       status_q, status_d;
   logic              done_q, done_d;

   logic arm_edge;
   logic trig_sel;
   logic abort;
   logic unused_ctrl;

   assign arm_edge    = ctrl[0] & ~ctrl0_q;
   assign trig_sel    = ctrl[1];
   assign abort       = ctrl[2];
   assign unused_ctrl = ^ctrl[31:3];

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         trig_seen_q <= 1'b0;
         ctrl0_q     <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         we_q        <= 1'b0;
         status_q    <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         trig_seen_q <= trig_seen_d;
         ctrl0_q     <= ctrl[0];
         addr_q      <= addr_d;
         data_q      <= data_d;
         we_q        <= we_d;
         status_q    <= status_d;
         done_q      <= done_d;
      end
   end

   // Next-state and BRAM write generation; abort overrides everything else.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      trig_seen_d = trig_seen_q;
      addr_d      = addr_q;
      data_d      = data_q;
      we_d        = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (arm_edge) begin
                  state_d     = S_ARMED;
                  count_d     = '0;
                  trig_seen_d = 1'b0;
               end
            end
            S_ARMED: begin
               if (!trig_sel) begin
                  state_d = S_CAPTURE;
               end else if (trig_in) begin
                  state_d     = S_CAPTURE;
                  trig_seen_d = 1'b1;
               end
            end
            S_CAPTURE: begin
               if (din_valid) begin
                  we_d    = 1'b1;
                  addr_d  = count_q[ADDR_W-1:0];
                  data_d  = din;
                  count_d = count_q + CNT_W'(1);
                  if (count_q == LAST_IDX) begin
                     state_d = S_DONE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Status word mirrors the registered state one cycle later.
   always_comb begin
      status_d             = '0;
      status_d[31]         = (state_q == S_DONE);
      status_d[30]         = (state_q == S_ARMED) || (state_q == S_CAPTURE);
      status_d[29]         = trig_seen_q;
      status_d[ADDR_W:0]   = count_q;
      done_d               = (state_q == S_DONE);
   end

   assign bram_addr = addr_q;
   assign bram_data = data_q;
   assign bram_we   = we_q;
   assign status    = status_q;
   assign done      = done_q;

endmodule
